// File: rtl/bipi_control_fsm.sv
// BIPI sequential control unit: IDLE/EXEC/WAIT/HALT sequencer with RAM-read wait states.
// Optional retired-instruction counter enabled by defining BIPI_INSTR_COUNTER_EN.
module bipi_control_fsm #(
  parameter int OPCODE_LENGTH = 5,
  parameter int RAM_LATENCY   = 1,
  parameter int COUNT_WIDTH   = 16
) (
  input  logic                     i_clock,
  input  logic                     i_reset,
  input  logic                     i_start,
  input  logic [OPCODE_LENGTH-1:0] i_opcode,
  input  logic                     i_acc_zero,
  output logic                     o_wrPC,
  output logic                     o_selPC,
  output logic                     o_wrACC,
  output logic [1:0]               o_selA,
  output logic                     o_selB,
  output logic [OPCODE_LENGTH-1:0] o_opcode,
  output logic                     o_wrRAM,
  output logic                     o_rdRAM,
  output logic                     o_busy,
  output logic                     o_halted,
  output logic                     o_illegal,
  output logic [COUNT_WIDTH-1:0]   o_instr_count
);

  typedef enum logic [1:0] {IDLE, EXEC, WAIT, HALT} state_t;

  localparam logic [3:0] LATENCY = 4'(RAM_LATENCY);

  localparam logic [OPCODE_LENGTH-1:0] OP_HALT = OPCODE_LENGTH'(0);
  localparam logic [OPCODE_LENGTH-1:0] OP_STO  = OPCODE_LENGTH'(1);
  localparam logic [OPCODE_LENGTH-1:0] OP_LD   = OPCODE_LENGTH'(2);
  localparam logic [OPCODE_LENGTH-1:0] OP_LDI  = OPCODE_LENGTH'(3);
  localparam logic [OPCODE_LENGTH-1:0] OP_ADD  = OPCODE_LENGTH'(4);
  localparam logic [OPCODE_LENGTH-1:0] OP_ADDI = OPCODE_LENGTH'(5);
  localparam logic [OPCODE_LENGTH-1:0] OP_SUB  = OPCODE_LENGTH'(6);
  localparam logic [OPCODE_LENGTH-1:0] OP_SUBI = OPCODE_LENGTH'(7);
  localparam logic [OPCODE_LENGTH-1:0] OP_AND  = OPCODE_LENGTH'(8);
  localparam logic [OPCODE_LENGTH-1:0] OP_ANDI = OPCODE_LENGTH'(9);
  localparam logic [OPCODE_LENGTH-1:0] OP_OR   = OPCODE_LENGTH'(10);
  localparam logic [OPCODE_LENGTH-1:0] OP_ORI  = OPCODE_LENGTH'(11);
  localparam logic [OPCODE_LENGTH-1:0] OP_XOR  = OPCODE_LENGTH'(12);
  localparam logic [OPCODE_LENGTH-1:0] OP_XORI = OPCODE_LENGTH'(13);
  localparam logic [OPCODE_LENGTH-1:0] OP_SHLI = OPCODE_LENGTH'(14);
  localparam logic [OPCODE_LENGTH-1:0] OP_SHRI = OPCODE_LENGTH'(15);
  localparam logic [OPCODE_LENGTH-1:0] OP_BEQ  = OPCODE_LENGTH'(16);
  localparam logic [OPCODE_LENGTH-1:0] OP_BNE  = OPCODE_LENGTH'(17);
  localparam logic [OPCODE_LENGTH-1:0] OP_JMP  = OPCODE_LENGTH'(18);

  localparam logic [1:0] SEL_RAM = 2'd0;
  localparam logic [1:0] SEL_IMM = 2'd1;
  localparam logic [1:0] SEL_ALU = 2'd2;

  state_t     state;
  logic [3:0] waitCnt;
  logic       illegalQ;
  logic       active;
  logic       lastCycle;
  logic       isHalt;
  logic       isIllegal;
  logic       isRamRead;

  assign active    = (state == EXEC) || (state == WAIT);
  // A RAM read retires in EXEC only when no wait states are configured.
  assign lastCycle = (state == WAIT) ? (waitCnt == 4'd1) : (LATENCY == 4'd0);

  always_comb begin
    o_wrPC    = 1'b0;
    o_selPC   = 1'b0;
    o_wrACC   = 1'b0;
    o_selA    = SEL_RAM;
    o_selB    = 1'b0;
    o_wrRAM   = 1'b0;
    o_rdRAM   = 1'b0;
    o_opcode  = '0;
    isHalt    = 1'b0;
    isIllegal = 1'b0;
    isRamRead = 1'b0;
    if (active) begin
      o_opcode = i_opcode;
      case (i_opcode)
        OP_HALT: isHalt = 1'b1;
        OP_STO: begin
          o_wrPC  = 1'b1;
          o_wrRAM = 1'b1;
        end
        OP_LD: begin
          isRamRead = 1'b1;
          o_rdRAM   = 1'b1;
          o_selA    = SEL_RAM;
          o_wrACC   = lastCycle;
          o_wrPC    = lastCycle;
        end
        OP_LDI: begin
          o_wrPC  = 1'b1;
          o_wrACC = 1'b1;
          o_selA  = SEL_IMM;
        end
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
          isRamRead = 1'b1;
          o_rdRAM   = 1'b1;
          o_selA    = SEL_ALU;
          o_selB    = 1'b0;
          o_wrACC   = lastCycle;
          o_wrPC    = lastCycle;
        end
        OP_ADDI, OP_SUBI, OP_ANDI, OP_ORI, OP_XORI, OP_SHLI, OP_SHRI: begin
          o_selA  = SEL_ALU;
          o_selB  = 1'b1;
          o_wrACC = 1'b1;
          o_wrPC  = 1'b1;
        end
        OP_BEQ: begin
          o_wrPC  = 1'b1;
          o_selPC = i_acc_zero;
        end
        OP_BNE: begin
          o_wrPC  = 1'b1;
          o_selPC = !i_acc_zero;
        end
        OP_JMP: begin
          o_wrPC  = 1'b1;
          o_selPC = 1'b1;
        end
        default: isIllegal = 1'b1;
      endcase
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state    <= IDLE;
      waitCnt  <= 4'd0;
      illegalQ <= 1'b0;
    end else begin
      case (state)
        IDLE: if (i_start) state <= EXEC;
        EXEC: begin
          if (isHalt) begin
            state <= HALT;
          end else if (isIllegal) begin
            state    <= HALT;
            illegalQ <= 1'b1;
          end else if (isRamRead && (LATENCY != 4'd0)) begin
            waitCnt <= LATENCY;
            state   <= WAIT;
          end
        end
        WAIT: begin
          waitCnt <= waitCnt - 4'd1;
          if (waitCnt == 4'd1) state <= EXEC;
        end
        HALT: state <= HALT;
        default: state <= IDLE;
      endcase
    end
  end

  assign o_busy    = active;
  assign o_halted  = (state == HALT);
  assign o_illegal = illegalQ;

`ifdef BIPI_INSTR_COUNTER_EN
  logic [COUNT_WIDTH-1:0] instrCount;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset)    instrCount <= '0;
    else if (o_wrPC) instrCount <= instrCount + COUNT_WIDTH'(1);
  end

  assign o_instr_count = instrCount;
`else
  assign o_instr_count = '0;
`endif

endmodule

// File: tb/tb_bipi_control_fsm.sv
// Scoreboard bench for bipi_control_fsm: two instances (RAM latency 2 and 3) share stimulus;
// each queued expectation names which instance the monitor compares against.
module tb_bipi_control_fsm;

  typedef struct packed {
    logic        wrPC;
    logic        selPC;
    logic        wrACC;
    logic [1:0]  selA;
    logic        selB;
    logic        wrRAM;
    logic        rdRAM;
    logic        busy;
    logic        halted;
    logic        illegal;
    logic [4:0]  op;
    logic [15:0] cnt;
  } outs_t;

  typedef struct {
    string tag;
    logic  sel;
    outs_t exp;
  } item_t;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [4:0] opcode;
  logic       accZero;

  logic        aWrPC, aSelPC, aWrACC, aSelB, aWrRAM, aRdRAM, aBusy, aHalted, aIllegal;
  logic [1:0]  aSelA;
  logic [4:0]  aOp;
  logic [15:0] aCnt;
  logic        bWrPC, bSelPC, bWrACC, bSelB, bWrRAM, bRdRAM, bBusy, bHalted, bIllegal;
  logic [1:0]  bSelA;
  logic [4:0]  bOp;
  logic [15:0] bCnt;

  bipi_control_fsm #(.OPCODE_LENGTH(5), .RAM_LATENCY(2), .COUNT_WIDTH(16)) dutA (
    .i_clock(clk), .i_reset(rst_n), .i_start(start), .i_opcode(opcode), .i_acc_zero(accZero),
    .o_wrPC(aWrPC), .o_selPC(aSelPC), .o_wrACC(aWrACC), .o_selA(aSelA), .o_selB(aSelB),
    .o_opcode(aOp), .o_wrRAM(aWrRAM), .o_rdRAM(aRdRAM), .o_busy(aBusy), .o_halted(aHalted),
    .o_illegal(aIllegal), .o_instr_count(aCnt)
  );

  bipi_control_fsm #(.OPCODE_LENGTH(5), .RAM_LATENCY(3), .COUNT_WIDTH(16)) dutB (
    .i_clock(clk), .i_reset(rst_n), .i_start(start), .i_opcode(opcode), .i_acc_zero(accZero),
    .o_wrPC(bWrPC), .o_selPC(bSelPC), .o_wrACC(bWrACC), .o_selA(bSelA), .o_selB(bSelB),
    .o_opcode(bOp), .o_wrRAM(bWrRAM), .o_rdRAM(bRdRAM), .o_busy(bBusy), .o_halted(bHalted),
    .o_illegal(bIllegal), .o_instr_count(bCnt)
  );

  outs_t actA, actB;
  assign actA = '{aWrPC, aSelPC, aWrACC, aSelA, aSelB, aWrRAM, aRdRAM, aBusy, aHalted, aIllegal, aOp, aCnt};
  assign actB = '{bWrPC, bSelPC, bWrACC, bSelB ? bSelA : bSelA, bSelB, bWrRAM, bRdRAM, bBusy, bHalted, bIllegal, bOp, bCnt};

  item_t q[$];
  int checks   = 0;
  int failures = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] ec(input int n);
`ifdef BIPI_INSTR_COUNTER_EN
    return 16'(n);
`else
    return 16'(n * 0);
`endif
  endfunction

  function automatic outs_t mk(input logic wrPC, selPC, wrACC, input logic [1:0] selA,
                               input logic selB, wrRAM, rdRAM, busy, halted, illegal,
                               input logic [4:0] op, input int cnt);
    outs_t o;
    o = '{wrPC, selPC, wrACC, selA, selB, wrRAM, rdRAM, busy, halted, illegal, op, ec(cnt)};
    return o;
  endfunction

  task automatic expect_out(input string tag, input logic sel, input outs_t e);
    item_t it;
    it.tag = tag;
    it.sel = sel;
    it.exp = e;
    q.push_back(it);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: outputs are combinational, so every cycle presents a value to compare.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      item_t it;
      outs_t act;
      it  = q.pop_front();
      act = it.sel ? actB : actA;
      checks++;
      if (act !== it.exp) begin
        failures++;
        $display("FAIL %s: got=%h expected=%h", it.tag, act, it.exp);
      end
    end
  end

  initial begin
    rst_n   = 1'b1;
    start   = 1'b0;
    opcode  = 5'd0;
    accZero = 1'b0;
    #2 rst_n = 1'b0;

    // ---- dutA, RAM_LATENCY=2 ----
    tick(); expect_out("reset", 0, mk(0,0,0,0,0,0,0,0,0,0,0,0));
    tick(); rst_n = 1'b1; start = 1'b1; opcode = 5'b00011;
            expect_out("idle", 0, mk(0,0,0,0,0,0,0,0,0,0,0,0));
    tick(); start = 1'b0;
            expect_out("ldi", 0, mk(1,0,1,1,0,0,0,1,0,0,5'd3,0));
    tick(); opcode = 5'b00100;
            expect_out("add_exec", 0, mk(0,0,0,2,0,0,1,1,0,0,5'd4,1));
    tick(); expect_out("add_wait1", 0, mk(0,0,0,2,0,0,1,1,0,0,5'd4,1));
    tick(); expect_out("add_wait2", 0, mk(1,0,1,2,0,0,1,1,0,0,5'd4,1));
    tick(); opcode = 5'b10000; accZero = 1'b1;
            expect_out("beq_taken", 0, mk(1,1,0,0,0,0,0,1,0,0,5'd16,2));
    tick(); accZero = 1'b0;
            expect_out("beq_not", 0, mk(1,0,0,0,0,0,0,1,0,0,5'd16,3));
    tick(); opcode = 5'b10001;
            expect_out("bne", 0, mk(1,1,0,0,0,0,0,1,0,0,5'd17,4));
    tick(); opcode = 5'b10010;
            expect_out("jmp", 0, mk(1,1,0,0,0,0,0,1,0,0,5'd18,5));
    tick(); opcode = 5'b00001;
            expect_out("sto", 0, mk(1,0,0,0,0,1,0,1,0,0,5'd1,6));
    tick(); opcode = 5'b01110;
            expect_out("shli", 0, mk(1,0,1,2,1,0,0,1,0,0,5'd14,7));
    tick(); opcode = 5'b00000;
            expect_out("halt_exec", 0, mk(0,0,0,0,0,0,0,1,0,0,5'd0,8));
    tick(); start = 1'b1; opcode = 5'b00011;
            expect_out("halted", 0, mk(0,0,0,0,0,0,0,0,1,0,5'd0,8));
    tick(); start = 1'b0;
            expect_out("halt_stays", 0, mk(0,0,0,0,0,0,0,0,1,0,5'd0,8));
    tick(); rst_n = 1'b0;
            expect_out("reset2", 0, mk(0,0,0,0,0,0,0,0,0,0,0,0));
    tick(); rst_n = 1'b1; start = 1'b1; opcode = 5'b11111;
            expect_out("idle2", 0, mk(0,0,0,0,0,0,0,0,0,0,0,0));
    tick(); start = 1'b0;
            expect_out("illegal_exec", 0, mk(0,0,0,0,0,0,0,1,0,0,5'd31,0));
    tick(); expect_out("illegal_halt", 0, mk(0,0,0,0,0,0,0,0,1,1,5'd0,0));
    tick(); rst_n = 1'b0;
            expect_out("illegal_reset", 0, mk(0,0,0,0,0,0,0,0,0,0,0,0));

    // ---- dutB, RAM_LATENCY=3 ----
    tick(); rst_n = 1'b1; start = 1'b1; opcode = 5'b00010;
            expect_out("b_idle", 1, mk(0,0,0,0,0,0,0,0,0,0,0,0));
    tick(); start = 1'b0;
            expect_out("b_ld_exec", 1, mk(0,0,0,0,0,0,1,1,0,0,5'd2,0));
    tick(); expect_out("b_ld_wait1", 1, mk(0,0,0,0,0,0,1,1,0,0,5'd2,0));
    tick(); rst_n = 1'b0;
            expect_out("b_reset_in_wait", 1, mk(0,0,0,0,0,0,0,0,0,0,0,0));
    tick(); rst_n = 1'b1;
            expect_out("b_idle_after", 1, mk(0,0,0,0,0,0,0,0,0,0,0,0));
    tick(); start = 1'b1; opcode = 5'b00011;
            expect_out("b_idle_start", 1, mk(0,0,0,0,0,0,0,0,0,0,0,0));
    tick(); start = 1'b0;
            expect_out("b_ldi", 1, mk(1,0,1,1,0,0,0,1,0,0,5'd3,0));
    tick(); opcode = 5'b00010;
            expect_out("b_ld2_exec", 1, mk(0,0,0,0,0,0,1,1,0,0,5'd2,1));
    tick(); expect_out("b_ld2_wait1", 1, mk(0,0,0,0,0,0,1,1,0,0,5'd2,1));
    tick(); expect_out("b_ld2_wait2", 1, mk(0,0,0,0,0,0,1,1,0,0,5'd2,1));
    tick(); expect_out("b_ld2_wait3", 1, mk(1,0,1,0,0,0,1,1,0,0,5'd2,1));
    tick(); opcode = 5'b10010;
            expect_out("b_jmp", 1, mk(1,1,0,0,0,0,0,1,0,0,5'd18,2));
    tick(); opcode = 5'b00001;
            expect_out("b_sto", 1, mk(1,0,0,0,0,1,0,1,0,0,5'd1,3));
    tick(); opcode = 5'b01001;
            expect_out("b_andi", 1, mk(1,0,1,2,1,0,0,1,0,0,5'd9,4));
    tick(); opcode = 5'b00000;
            expect_out("b_halt_exec", 1, mk(0,0,0,0,0,0,0,1,0,0,5'd0,5));
    tick(); expect_out("b_halted", 1, mk(0,0,0,0,0,0,0,0,1,0,5'd0,5));

    tick();
    tick();
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain: pending=%0d required=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bipi_control_fsm.md
# bipi_control_fsm

Sequential control unit for the BIPI datapath, replacing the purely combinational opcode decoder. It runs an IDLE/EXEC/WAIT/HALT state machine and inserts a parametrised number of wait cycles for data-RAM reads. It extends the instruction set with logic, shift and branch opcodes, and latches halt and illegal-opcode status. It sits between the program memory opcode field and the PC, accumulator, ALU and data RAM enables.

## Interface
- OPCODE_LENGTH, 5: opcode width.
- RAM_LATENCY, 1: extra cycles a data-RAM read needs (0..15).
- COUNT_WIDTH, 16: retired-instruction counter width.
- i_clock  in  1  system clock; all state updates on the rising edge.
- i_reset  in  1  asynchronous, active-low reset.
- i_start  in  1  run request, sampled in IDLE only.
- i_opcode  in  OPCODE_LENGTH  opcode from program memory.
- i_acc_zero  in  1  accumulator == 0 flag, used by branches.
- o_wrPC  out  1  PC update enable.
- o_selPC  out  1  0 = PC+1, 1 = branch target (instruction operand).
- o_wrACC  out  1  accumulator write enable.
- o_selA  out  2  accumulator source: 0 = RAM, 1 = immediate, 2 = ALU.
- o_selB  out  1  ALU operand B: 0 = RAM, 1 = immediate.
- o_opcode  out  OPCODE_LENGTH  opcode forwarded to the ALU.
- o_wrRAM, o_rdRAM  out  1 each  data RAM write/read enables.
- o_busy  out  1  high in EXEC or WAIT.
- o_halted  out  1  high in HALT.
- o_illegal  out  1  sticky, set when HALT was entered on an undefined opcode.
- o_instr_count  out  COUNT_WIDTH  retired-instruction count.

## Operation
- State is registered. All control outputs are combinational from the current state, i_opcode and i_acc_zero.
- In IDLE and HALT, all control outputs and o_opcode are 0.
- In EXEC and WAIT, o_opcode = i_opcode.
- IDLE: i_start=1 moves the FSM to EXEC.
- EXEC, one instruction per cycle, unless a RAM read with RAM_LATENCY>0 is decoded.
- 00000 HALT: all controls 0; next state is HALT.
- 00001 STO: wrPC=1, wrRAM=1.
- 00010 LD: rdRAM=1, selA=0, wrACC and wrPC on the final cycle.
- 00011 LDI: wrPC=1, wrACC=1, selA=1.
- Variable ALU ops, 00100/00110/01000/01010/01100 (ADD, SUB, AND, OR, XOR):
  - rdRAM=1, selA=2, selB=0.
  - wrACC and wrPC on the final cycle.
- Immediate ALU ops, 00101/00111/01001/01011/01101/01110/01111 (ADDI, SUBI, ANDI, ORI, XORI, SHLI, SHRI):
  - selA=2, selB=1, wrACC=1, wrPC=1.
- 10000 BEQ: wrPC=1, selPC=i_acc_zero.
- 10001 BNE: wrPC=1, selPC=!i_acc_zero.
- 10010 JMP: wrPC=1, selPC=1.
- Any other opcode: all controls 0; next state is HALT and o_illegal is set.
- RAM-read ops (LD and the variable ALU ops) with RAM_LATENCY=N>0:
  - EXEC loads a wait counter with N and moves to WAIT.
  - WAIT holds rdRAM, selA and selB as in EXEC, with wrACC=0 and wrPC=0.
  - The counter decrements every cycle.
  - In the WAIT cycle where counter==1, wrACC=1 and wrPC=1, and the next state is EXEC.
  - Total occupancy is N+1 cycles.
- With RAM_LATENCY=0, RAM-read ops complete in EXEC in a single cycle.
- i_opcode must stay stable through WAIT; the PC does not change, so this holds by construction.
- HALT is left only by reset. i_start is ignored in EXEC, WAIT and HALT.

## Timing
- Reset (i_reset=0) takes effect immediately, asynchronously:
  - state=IDLE, wait counter=0, o_illegal=0, o_instr_count=0.
  - Every control output, o_opcode, o_busy and o_halted = 0.
- Reset asserted mid-WAIT aborts the instruction; no wrACC or wrPC pulse is produced.
- i_start sampled high at edge k means EXEC is active from edge k. The first instruction's controls are valid in cycle k..k+1.
- o_halted and o_illegal rise at the edge after the HALT or illegal opcode is seen in EXEC.
- o_instr_count increments at each edge where o_wrPC=1, and wraps from 2^COUNT_WIDTH-1 to 0.
- HALT and illegal opcodes are not counted.

## Configuration
- BIPI_INSTR_COUNTER_EN defined: the counter is implemented as above.
- Without it, o_instr_count is tied to 0 and no counter flops are generated.

## Test plan
- Reset, i_start=1 for one cycle, opcode 00011 -> next cycle o_wrPC=1, o_wrACC=1, o_selA=1, o_busy=1, o_rdRAM=0.
- RAM_LATENCY=2, opcode 00100:
  - o_rdRAM=1, o_selA=2, o_selB=0 for exactly 3 cycles.
  - o_wrACC and o_wrPC high only in cycle 3.
  - o_instr_count goes 0 -> 1.
- Opcode 10000 with i_acc_zero=1 -> o_selPC=1, o_wrPC=1; with i_acc_zero=0 -> o_selPC=0, o_wrPC=1. Opcode 10010 -> o_selPC=1 regardless of the flag.
- Opcode 00000 -> next cycle o_halted=1, o_busy=0, all controls 0; pulsing i_start leaves the FSM in HALT.
- Opcode 11111 -> o_illegal=1, o_halted=1, o_wrPC never asserted; reset clears both.
- RAM_LATENCY=3, i_reset=0 during the 2nd WAIT cycle:
  - All outputs 0 immediately, state IDLE, count 0.
  - After release, i_start resumes normal operation.
  - Without BIPI_INSTR_COUNTER_EN, o_instr_count stays 0 after 5 retired instructions.
